// File: rtl/pf_ddr_lane_dly_ctrl.sv
// Transmit delay-line controller for one DDR byte lane. It turns tap commands into spaced
// LOAD/DIRECTION/MOVE pulses on the selected IOD and tracks the current tap of every channel.
module pf_ddr_lane_dly_ctrl #(
    parameter int unsigned NUM_BITS = 9,
    parameter int unsigned TAP_W    = 8,
    parameter int unsigned INIT_TAP = 1,
    parameter int unsigned MAX_TAP  = 255,
    parameter int unsigned MOVE_GAP = 4,
    parameter int unsigned CH_W     = $clog2(NUM_BITS)
) (
    input  logic                FAB_CLK,
    input  logic                ARST_N,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic [1:0]          CMD_OP,
    input  logic [CH_W-1:0]     CMD_CH,
    input  logic [TAP_W-1:0]    CMD_TAP,
    output logic                RSP_VALID,
    output logic                RSP_ERR,
    output logic [TAP_W-1:0]    RSP_TAP,
    output logic [NUM_BITS-1:0] DLY_MOVE,
    output logic [NUM_BITS-1:0] DLY_DIRECTION,
    output logic [NUM_BITS-1:0] DLY_LOAD,
    input  logic [NUM_BITS-1:0] DLY_OUT_OF_RANGE,
    input  logic [CH_W-1:0]     TAP_RD_CH,
    output logic [TAP_W-1:0]    TAP_RD_DATA
);

    localparam int unsigned      CNT_W      = $clog2(MOVE_GAP + 2);
    localparam logic [CNT_W-1:0] LP_CNT_G   = CNT_W'(MOVE_GAP);
    localparam logic [CNT_W-1:0] LP_CNT_G1  = CNT_W'(MOVE_GAP - 1);
    localparam logic [TAP_W-1:0] LP_MAX_TAP = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] LP_INI_TAP = TAP_W'(INIT_TAP);
    localparam logic [CH_W:0]    LP_NB      = (CH_W + 1)'(NUM_BITS);
    localparam logic [1:0]       OP_ABS     = 2'b00;
    localparam logic [1:0]       OP_INC     = 2'b01;
    localparam logic [1:0]       OP_DEC     = 2'b10;
    localparam logic [1:0]       OP_LOAD    = 2'b11;

    typedef enum logic [3:0] {
        ST_INIT, ST_INIT_GAP, ST_IDLE, ST_CALC, ST_SETDIR, ST_PULSE, ST_GAP, ST_LOAD, ST_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [1:0]          r_op;
    logic [CH_W-1:0]     r_ch;
    logic [TAP_W-1:0]    r_cmd_tap;
    logic [TAP_W-1:0]    r_steps, w_steps_nxt;
    logic                r_up, w_up_nxt;
    logic [TAP_W-1:0]    r_tap [NUM_BITS];
    logic                r_ready, w_ready_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic                r_rsp_err, w_rsp_err_nxt;
    logic [TAP_W-1:0]    r_rsp_tap, w_rsp_tap_nxt;
    logic [NUM_BITS-1:0] r_move, w_move_nxt;
    logic [NUM_BITS-1:0] r_dir, w_dir_nxt;
    logic [NUM_BITS-1:0] r_load, w_load_nxt;
    logic                w_tap_we;
    logic [TAP_W-1:0]    w_tap_wdata;

    logic                w_cmd_acc, w_ch_ok, w_oor, w_up;
    logic [NUM_BITS-1:0] w_ch_mask;
    logic [TAP_W-1:0]    w_cur, w_target, w_steps, w_step_tap;
    logic [TAP_W:0]      w_sum;
    logic signed [TAP_W:0] w_diff;

    assign w_cmd_acc  = (r_state == ST_IDLE) && CMD_VALID;
    assign w_ch_ok    = ({1'b0, r_ch} < LP_NB);
    assign w_ch_mask  = w_ch_ok ? (NUM_BITS'(1) << r_ch) : '0;
    assign w_cur      = w_ch_ok ? r_tap[r_ch] : '0;
    assign w_sum      = {1'b0, w_cur} + {1'b0, r_cmd_tap};
    assign w_diff     = $signed({1'b0, w_cur}) - $signed({1'b0, r_cmd_tap});
    assign w_oor      = |(DLY_OUT_OF_RANGE & w_ch_mask);
    assign w_step_tap = r_up ? (w_cur + TAP_W'(1)) : (w_cur - TAP_W'(1));

    // Saturating target tap for the move ops
    always_comb begin
        w_target = w_cur;
        case (r_op)
            OP_ABS:  w_target = (r_cmd_tap > LP_MAX_TAP) ? LP_MAX_TAP : r_cmd_tap;
            OP_INC:  w_target = (w_sum > {1'b0, LP_MAX_TAP}) ? LP_MAX_TAP : w_sum[TAP_W-1:0];
            OP_DEC:  w_target = w_diff[TAP_W] ? '0 : w_diff[TAP_W-1:0];
            default: w_target = w_cur;
        endcase
    end

    assign w_up    = (w_target > w_cur);
    assign w_steps = w_up ? (w_target - w_cur) : (w_cur - w_target);

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) r_state <= ST_INIT;
        else         r_state <= w_state_nxt;
    end

    // Next state plus next value of every registered output
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_steps_nxt     = r_steps;
        w_up_nxt        = r_up;
        w_ready_nxt     = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_tap_nxt   = r_rsp_tap;
        w_move_nxt      = '0;
        w_load_nxt      = '0;
        w_dir_nxt       = r_dir;
        w_tap_we        = 1'b0;
        w_tap_wdata     = w_step_tap;
        case (r_state)
            ST_INIT: begin
                w_load_nxt  = '1;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_INIT_GAP;
            end
            // The registered load lands in the first INIT_GAP cycle, so G more follow it
            ST_INIT_GAP: begin
                if (r_cnt == LP_CNT_G) w_state_nxt = ST_IDLE;
                else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
            ST_IDLE: begin
                if (CMD_VALID) w_state_nxt = ST_CALC;
            end
            ST_CALC: begin
                if (!w_ch_ok) begin
                    w_state_nxt     = ST_DONE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_tap_nxt   = '0;
                end else if (r_op == OP_LOAD) begin
                    w_state_nxt = ST_LOAD;
                    w_load_nxt  = w_ch_mask;
                    w_cnt_nxt   = '0;
                end else if (w_steps == '0) begin
                    w_state_nxt     = ST_DONE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_tap_nxt   = w_cur;
                end else begin
                    w_state_nxt = ST_SETDIR;
                    w_steps_nxt = w_steps;
                    w_up_nxt    = w_up;
                    w_dir_nxt   = (r_dir & ~w_ch_mask) | (w_up ? w_ch_mask : '0);
                end
            end
            ST_SETDIR: begin
                w_state_nxt = ST_PULSE;
                w_move_nxt  = w_ch_mask;
            end
            ST_PULSE: begin
                w_state_nxt = ST_GAP;
                w_cnt_nxt   = '0;
            end
            // Range flag is judged only on the last settle cycle of each step
            ST_GAP: begin
                if (r_cnt != LP_CNT_G1) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else if (w_oor) begin
                    w_state_nxt     = ST_DONE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_tap_nxt   = w_cur;
                end else begin
                    w_tap_we    = 1'b1;
                    w_steps_nxt = r_steps - TAP_W'(1);
                    if (r_steps == TAP_W'(1)) begin
                        w_state_nxt     = ST_DONE;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_tap_nxt   = w_step_tap;
                    end else begin
                        w_state_nxt = ST_PULSE;
                        w_move_nxt  = w_ch_mask;
                    end
                end
            end
            ST_LOAD: begin
                if (r_cnt == LP_CNT_G) begin
                    w_tap_we        = 1'b1;
                    w_tap_wdata     = LP_INI_TAP;
                    w_state_nxt     = ST_DONE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_tap_nxt   = LP_INI_TAP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_INIT;
        endcase
        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_cnt       <= '0;
            r_op        <= '0;
            r_ch        <= '0;
            r_cmd_tap   <= '0;
            r_steps     <= '0;
            r_up        <= 1'b0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_tap   <= '0;
            r_move      <= '0;
            r_dir       <= '0;
            r_load      <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_steps     <= w_steps_nxt;
            r_up        <= w_up_nxt;
            r_ready     <= w_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_tap   <= w_rsp_tap_nxt;
            r_move      <= w_move_nxt;
            r_dir       <= w_dir_nxt;
            r_load      <= w_load_nxt;
            if (w_cmd_acc) begin
                r_op      <= CMD_OP;
                r_ch      <= CMD_CH;
                r_cmd_tap <= CMD_TAP;
            end
        end
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            for (int i = 0; i < int'(NUM_BITS); i++) r_tap[i] <= LP_INI_TAP;
        end else if (w_tap_we) begin
            r_tap[r_ch] <= w_tap_wdata;
        end
    end

    assign CMD_READY     = r_ready;
    assign RSP_VALID     = r_rsp_valid;
    assign RSP_ERR       = r_rsp_err;
    assign RSP_TAP       = r_rsp_tap;
    assign DLY_MOVE      = r_move;
    assign DLY_DIRECTION = r_dir;
    assign DLY_LOAD      = r_load;
    assign TAP_RD_DATA   = ({1'b0, TAP_RD_CH} < LP_NB) ? r_tap[TAP_RD_CH] : '0;

endmodule
